// File: rtl/vga_cell_sampler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vga_cell_sampler: recovers 640x480 timing from a TinyVGA bus and streams  |
// | one alive bit per 8x8 cell. Optional macro: VGA_SAMPLER_POPCOUNT_EN       |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module vga_cell_sampler #(
  parameter int H_TOTAL      = 800,
  parameter int H_SYNC_START = 656,
  parameter int V_TOTAL      = 525,
  parameter int V_SYNC_START = 490,
  parameter int WIN_X0       = 128,
  parameter int WIN_Y0       = 160,
  parameter int COLS         = 48,
  parameter int ROWS         = 20,
  parameter int SAMPLE_OFS   = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  vga_in,
  output logic        locked,
  output logic        sync_err,
  output logic        cell_valid,
  output logic [5:0]  cell_col,
  output logic [4:0]  cell_row,
  output logic        cell_alive,
  output logic        frame_done,
  output logic [10:0] alive_count
);

  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] C_H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] C_H_SYNC  = HW'(H_SYNC_START);
  localparam logic [VW-1:0] C_V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] C_V_SYNC  = VW'(V_SYNC_START);
  localparam logic [HW-1:0] C_WIN_X0  = HW'(WIN_X0);
  localparam logic [VW-1:0] C_WIN_Y0  = VW'(WIN_Y0);
  localparam logic [HW-1:0] C_WIN_W   = HW'(8 * COLS);
  localparam logic [VW-1:0] C_WIN_H   = VW'(8 * ROWS);
  localparam logic [2:0]    C_OFS     = 3'(SAMPLE_OFS);
  localparam logic [5:0]    C_LAST_COL = 6'(COLS - 1);
  localparam logic [4:0]    C_LAST_ROW = 5'(ROWS - 1);

  localparam logic [1:0] S_HUNT   = 2'd0;
  localparam logic [1:0] S_LOCK_H = 2'd1;
  localparam logic [1:0] S_LOCK_V = 2'd2;
  localparam logic [1:0] S_LOCKED = 2'd3;

  logic          r_hs_q;
  logic          r_vs_q;
  logic [HW-1:0] r_h_cnt;
  logic [VW-1:0] r_v_cnt;
  logic [1:0]    r_state;
  logic [1:0]    w_next_state;

  logic          w_hfall;
  logic          w_vfall;
  logic [HW-1:0] w_h_cur;
  logic [VW-1:0] w_v_cur;
  logic          w_h_wrap;
  logic [HW-1:0] w_h_next;
  logic [VW-1:0] w_v_next;
  logic          w_h_at_sync;
  logic          w_lock_err;
  logic          w_sync_err;
  logic          w_sample;
  logic [HW-1:0] w_hx;
  logic [VW-1:0] w_vy;
  logic          w_last;
  logic          w_unused;

  // Colour bits other than R1 carry no information for the cell grid.
  assign w_unused = &{1'b0, vga_in[6:4], vga_in[2:1]};

  assign w_hfall = r_hs_q & ~vga_in[7];
  assign w_vfall = r_vs_q & ~vga_in[3];

  // Sync falls re-anchor the counters to the position of the current sample.
  assign w_h_cur  = w_hfall ? C_H_SYNC : r_h_cnt;
  assign w_v_cur  = w_vfall ? C_V_SYNC : r_v_cnt;
  assign w_h_wrap = (w_h_cur == C_H_LAST);
  assign w_h_next = w_h_wrap ? '0 : w_h_cur + HW'(1);
  assign w_v_next = !w_h_wrap ? w_v_cur :
                    (w_v_cur == C_V_LAST) ? '0 : w_v_cur + VW'(1);

  assign w_h_at_sync = (r_h_cnt == C_H_SYNC);
  assign w_lock_err  = (w_hfall && !w_h_at_sync) ||
                       (w_vfall && ((r_h_cnt != '0) || (r_v_cnt != C_V_SYNC)));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hs_q  <= 1'b1;
      r_vs_q  <= 1'b1;
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else begin
      r_hs_q  <= vga_in[7];
      r_vs_q  <= vga_in[3];
      r_h_cnt <= w_h_next;
      r_v_cnt <= w_v_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_HUNT;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_HUNT: begin
        if (w_hfall) w_next_state = S_LOCK_H;
      end
      S_LOCK_H: begin
        if (w_hfall) w_next_state = w_h_at_sync ? S_LOCK_V : S_HUNT;
      end
      S_LOCK_V: begin
        if (w_vfall) begin
          w_next_state = (w_h_cur == '0) ? S_LOCKED : S_HUNT;
        end else if (w_hfall && !w_h_at_sync) begin
          w_next_state = S_HUNT;
        end
      end
      S_LOCKED: begin
        if (w_lock_err) w_next_state = S_HUNT;
      end
      default: w_next_state = S_HUNT;
    endcase
  end

  // Out-of-window positions wrap to large unsigned offsets and fail the bound.
  assign w_hx = w_h_cur - C_WIN_X0;
  assign w_vy = w_v_cur - C_WIN_Y0;

  always_comb begin
    w_sync_err = 1'b0;
    w_sample   = 1'b0;
    if (r_state == S_LOCKED) begin
      w_sync_err = w_lock_err;
      w_sample   = !w_lock_err && (w_hx < C_WIN_W) && (w_vy < C_WIN_H) &&
                   (w_hx[2:0] == C_OFS) && (w_vy[2:0] == C_OFS);
    end
  end

  assign w_last = cell_valid && (cell_col == C_LAST_COL) && (cell_row == C_LAST_ROW);

  always_ff @(posedge clk) begin
    if (reset) begin
      locked     <= 1'b0;
      sync_err   <= 1'b0;
      cell_valid <= 1'b0;
      cell_col   <= '0;
      cell_row   <= '0;
      cell_alive <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      locked     <= (w_next_state == S_LOCKED);
      sync_err   <= w_sync_err;
      cell_valid <= w_sample;
      frame_done <= w_last;
      if (w_sample) begin
        cell_col   <= 6'(w_hx >> 3);
        cell_row   <= 5'(w_vy >> 3);
        cell_alive <= vga_in[0];
      end
    end
  end

`ifdef VGA_SAMPLER_POPCOUNT_EN
  logic [10:0] r_pop;
  logic [10:0] w_pop_next;
  logic        w_first;

  // Cell (0,0) restarts the count, so a frame aborted by lock loss is dropped.
  assign w_first = (cell_col == '0) && (cell_row == '0);

  always_comb begin
    w_pop_next = r_pop;
    if (cell_valid) begin
      w_pop_next = (w_first ? 11'd0 : r_pop) + {10'd0, cell_alive};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pop       <= '0;
      alive_count <= '0;
    end else begin
      r_pop <= w_pop_next;
      if (w_last) alive_count <= w_pop_next;
    end
  end
`else
  assign alive_count = 11'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_cell_sampler.sv
`default_nettype none
// tb_vga_cell_sampler: directed bench with a reduced raster (48x32, 4x2 cells)
// so each frame is 1536 clocks.
module tb_vga_cell_sampler;

  localparam int HT = 48, HS = 40, VT = 32, VS = 28;
  localparam int X0 = 8, Y0 = 4, NC = 4, NR = 2, OFS = 3;
  localparam int FRAME = HT * VT;
`ifdef VGA_SAMPLER_POPCOUNT_EN
  localparam logic [10:0] EXP_CHK = 11'd4;
`else
  localparam logic [10:0] EXP_CHK = 11'd0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  vga_in;
  logic        locked, sync_err, cell_valid, cell_alive, frame_done;
  logic [5:0]  cell_col;
  logic [4:0]  cell_row;
  logic [10:0] alive_count;

  int total = 0, bad = 0;
  int h = 0, v = 0, glitch_line = -1;
  bit dead = 1'b0;

  int n_valid = 0, n_unl = 0, n_order = 0, n_abad = 0;
  int n_done = 0, n_dbad = 0, n_err = 0;
  int ec = 0, er = 0;
  bit prev_last = 1'b0;

  vga_cell_sampler #(
    .H_TOTAL(HT), .H_SYNC_START(HS), .V_TOTAL(VT), .V_SYNC_START(VS),
    .WIN_X0(X0), .WIN_Y0(Y0), .COLS(NC), .ROWS(NR), .SAMPLE_OFS(OFS)
  ) dut (
    .clk(clk), .reset(reset), .vga_in(vga_in), .locked(locked),
    .sync_err(sync_err), .cell_valid(cell_valid), .cell_col(cell_col),
    .cell_row(cell_row), .cell_alive(cell_alive), .frame_done(frame_done),
    .alive_count(alive_count)
  );

  always #5 clk = ~clk;

  // Stream monitor: expected raster position restarts whenever lock is absent.
  always @(negedge clk) begin : mon
    bit exp_a;
    if (frame_done === 1'b1) begin
      n_done++;
      if (!prev_last) n_dbad++;
    end
    prev_last = 1'b0;
    if (sync_err === 1'b1) n_err++;
    if (cell_valid === 1'b1) begin
      n_valid++;
      if (locked !== 1'b1) n_unl++;
      if (int'(cell_col) != ec || int'(cell_row) != er) n_order++;
      exp_a = !dead && (((ec ^ er) & 1) != 0);
      if (cell_alive !== exp_a) n_abad++;
      prev_last = (ec == NC - 1) && (er == NR - 1);
      if (ec == NC - 1) begin
        ec = 0;
        er = (er == NR - 1) ? 0 : er + 1;
      end else begin
        ec++;
      end
    end
    if (locked !== 1'b1) begin
      ec = 0;
      er = 0;
    end
  end

  // Drive one pixel; non-sampled pixels of a cell carry the inverse value.
  task automatic step();
    int hs0, dx, dy;
    logic hs, vs, r1, al, sp;
    hs0 = (v == glitch_line) ? HS + 1 : HS;
    hs  = (h >= hs0 && h < hs0 + 4) ? 1'b0 : 1'b1;
    vs  = (v >= VS && v < VS + 2) ? 1'b0 : 1'b1;
    dx  = h - X0;
    dy  = v - Y0;
    r1  = 1'b0;
    if (!dead) begin
      if (dx >= 0 && dx < 8 * NC && dy >= 0 && dy < 8 * NR) begin
        al = (((dx / 8) ^ (dy / 8)) & 1) != 0;
        sp = (dx % 8 == OFS) && (dy % 8 == OFS);
        r1 = sp ? al : ~al;
      end else begin
        r1 = 1'b1;
      end
    end
    vga_in = {hs, 1'b0, 1'b1, ~r1, vs, 1'b1, 1'b0, r1};
    @(posedge clk);
    #1;
    if (h == HT - 1) begin
      h = 0;
      v = (v == VT - 1) ? 0 : v + 1;
    end else begin
      h++;
    end
  endtask

  task automatic run_to_origin();
    while (h != 0 || v != 0) step();
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    vga_in = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      total++;
      if ({cell_valid, frame_done, sync_err} !== 3'b000) begin
        bad++;
        $display("FAIL rst_pulses: got %b want 000", {cell_valid, frame_done, sync_err});
      end
    end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL rst_locked: got %b want 0", locked); end
    total++; if (cell_col !== 6'd0) begin bad++; $display("FAIL rst_col: got %0d want 0", cell_col); end
    total++; if (cell_row !== 5'd0) begin bad++; $display("FAIL rst_row: got %0d want 0", cell_row); end
    total++; if (cell_alive !== 1'b0) begin bad++; $display("FAIL rst_alive: got %b want 0", cell_alive); end
    total++; if (alive_count !== 11'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", alive_count); end
  endtask

  task automatic test_lock();
    int n, b_err;
    reset = 1'b0;
    h = 17;
    v = 10;
    b_err = n_err;
    n = 0;
    while (locked !== 1'b1 && n < 3 * FRAME) begin
      step();
      n++;
    end
    total++; if (n != 848) begin bad++; $display("FAIL lock_cycles: got %0d want 848", n); end
    total++; if (n_err - b_err != 0) begin bad++; $display("FAIL lock_syncerr: got %0d want 0", n_err - b_err); end
  endtask

  task automatic check_frame(input string name, input int frames, input logic [10:0] exp_cnt);
    int b_valid, b_done, b_dbad, b_order, b_abad, b_unl, b_err;
    run_to_origin();
    b_valid = n_valid; b_done = n_done; b_dbad = n_dbad; b_order = n_order;
    b_abad = n_abad; b_unl = n_unl; b_err = n_err;
    repeat (frames * FRAME) step();
    total++; if (n_valid - b_valid != 8 * frames) begin bad++; $display("FAIL %s_valid: got %0d want %0d", name, n_valid - b_valid, 8 * frames); end
    total++; if (n_done - b_done != frames) begin bad++; $display("FAIL %s_done: got %0d want %0d", name, n_done - b_done, frames); end
    total++; if (n_dbad - b_dbad != 0) begin bad++; $display("FAIL %s_done_pos: got %0d want 0", name, n_dbad - b_dbad); end
    total++; if (n_order - b_order != 0) begin bad++; $display("FAIL %s_order: got %0d want 0", name, n_order - b_order); end
    total++; if (n_abad - b_abad != 0) begin bad++; $display("FAIL %s_alive: got %0d want 0", name, n_abad - b_abad); end
    total++; if (n_unl - b_unl != 0) begin bad++; $display("FAIL %s_unlocked_valid: got %0d want 0", name, n_unl - b_unl); end
    total++; if (n_err - b_err != 0) begin bad++; $display("FAIL %s_syncerr: got %0d want 0", name, n_err - b_err); end
    total++; if (alive_count !== exp_cnt) begin bad++; $display("FAIL %s_count: got %0d want %0d", name, alive_count, exp_cnt); end
  endtask

  task automatic test_checkerboard();
    check_frame("chk", 1, EXP_CHK);
  endtask

  task automatic test_hsync_glitch();
    int b_valid, b_done, b_err, b_unl;
    run_to_origin();
    while (v != 10) step();
    b_valid = n_valid; b_done = n_done; b_err = n_err; b_unl = n_unl;
    glitch_line = 10;
    while (!(v == 10 && h == 41)) step();
    step();
    total++; if (sync_err !== 1'b1) begin bad++; $display("FAIL glitch_err: got %b want 1", sync_err); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL glitch_locked: got %b want 0", locked); end
    step();
    total++; if (sync_err !== 1'b0) begin bad++; $display("FAIL glitch_err_width: got %b want 0", sync_err); end
    while (v != 11) step();
    glitch_line = -1;
    run_to_origin();
    total++; if (n_err - b_err != 1) begin bad++; $display("FAIL glitch_err_cycles: got %0d want 1", n_err - b_err); end
    total++; if (n_valid - b_valid != 0) begin bad++; $display("FAIL glitch_valid: got %0d want 0", n_valid - b_valid); end
    total++; if (n_unl - b_unl != 0) begin bad++; $display("FAIL glitch_unlocked_valid: got %0d want 0", n_unl - b_unl); end
    total++; if (n_done - b_done != 0) begin bad++; $display("FAIL glitch_done: got %0d want 0", n_done - b_done); end
    total++; if (alive_count !== EXP_CHK) begin bad++; $display("FAIL glitch_count: got %0d want %0d", alive_count, EXP_CHK); end
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL glitch_relock: got %b want 1", locked); end
    check_frame("relock", 1, EXP_CHK);
  endtask

  task automatic test_dead_board();
    run_to_origin();
    dead = 1'b1;
    check_frame("dead", 1, 11'd0);
    dead = 1'b0;
  endtask

  task automatic test_back_to_back();
    check_frame("b2b", 2, EXP_CHK);
  endtask

  task automatic test_reset_midframe();
    int b_valid, b_done;
    run_to_origin();
    while (v != 10) step();
    reset = 1'b1;
    step();
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL mrst_locked: got %b want 0", locked); end
    total++; if (cell_col !== 6'd0) begin bad++; $display("FAIL mrst_col: got %0d want 0", cell_col); end
    total++; if (cell_alive !== 1'b0) begin bad++; $display("FAIL mrst_alive: got %b want 0", cell_alive); end
    total++; if (alive_count !== 11'd0) begin bad++; $display("FAIL mrst_count: got %0d want 0", alive_count); end
    total++; if ({cell_valid, frame_done, sync_err} !== 3'b000) begin bad++; $display("FAIL mrst_pulses: got %b want 000", {cell_valid, frame_done, sync_err}); end
    reset = 1'b0;
    b_valid = n_valid;
    b_done  = n_done;
    run_to_origin();
    total++; if (n_valid - b_valid != 0) begin bad++; $display("FAIL mrst_valid: got %0d want 0", n_valid - b_valid); end
    total++; if (n_done - b_done != 0) begin bad++; $display("FAIL mrst_done: got %0d want 0", n_done - b_done); end
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL mrst_relock: got %b want 1", locked); end
    check_frame("mrst_next", 1, EXP_CHK);
  endtask

  initial begin
    test_reset();
    test_lock();
    test_checkerboard();
    test_hsync_glitch();
    test_dead_board();
    test_back_to_back();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
